// File: rtl/fifo_umbrales.sv
// -----------------------------------------------------------------------------
// fifo_umbrales
//
// Synchronous single-clock FIFO with programmable almost-empty / almost-full
// thresholds. It is the per-channel storage element of the transaction layer.
// Overflow and underflow are reported on a sticky error flag.
//
// Ports:
//   clk                    : single clock; all state changes on its rising edge
//   reset_L                : asynchronous, active-low reset
//   push / pop             : write / read requests, sampled on the rising edge
//   data_in                : write data, captured on an accepted push
//   almost_empty_threshold : almost-empty level (from the layer FSM)
//   almost_full_threshold  : almost-full level (from the layer FSM)
//   data_out               : registered read data (1-cycle read latency)
//   valid_out              : data_out holds a word popped at the last edge
//   count                  : current occupancy, 0..FIFO_DEPTH
//   empty / full           : count == 0 / count == FIFO_DEPTH
//   almost_empty           : count <= almost_empty_threshold
//   almost_full            : count >= almost_full_threshold
//   error                  : sticky overflow/underflow flag, cleared by reset
// -----------------------------------------------------------------------------
module fifo_umbrales #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FIFO_WORD_SIZE = 10,
    parameter int FIFO_PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      push,
    input  logic                      pop,
    input  logic [FIFO_WORD_SIZE-1:0] data_in,
    input  logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold,
    input  logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic                      valid_out,
    output logic [FIFO_PTR_SIZE:0]    count,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_empty,
    output logic                      almost_full,
    output logic                      error
);

    localparam logic [FIFO_PTR_SIZE:0] DEPTH_C = (FIFO_PTR_SIZE+1)'(FIFO_DEPTH);

    logic [FIFO_WORD_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_SIZE-1:0]  r_wr_ptr;
    logic [FIFO_PTR_SIZE-1:0]  r_rd_ptr;
    logic [FIFO_PTR_SIZE:0]    r_count;
    logic [FIFO_WORD_SIZE-1:0] r_data_out;
    logic                      r_valid;
    logic                      r_error;

    logic w_empty;
    logic w_full;
    logic w_pop_acc;
    logic w_push_acc;
    logic w_overflow;
    logic w_underflow;

    // Flags come straight from the occupancy counter, never from the pointers.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A pop needs data already stored: no read-through on an empty FIFO.
    assign w_pop_acc  = pop & ~w_empty;
    // When full, a push is still accepted if a pop frees a slot on this edge.
    assign w_push_acc = push & (~w_full | w_pop_acc);

    assign w_overflow  = push & w_full & ~w_pop_acc;
    assign w_underflow = pop & w_empty;

    // Storage: not reset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Control state and registered read port.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_valid    <= 1'b1;
            end else begin
                r_valid    <= 1'b0;
            end

            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_overflow || w_underflow) begin
                r_error <= 1'b1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign valid_out    = r_valid;
    assign count        = r_count;
    assign empty        = w_empty;
    assign full         = w_full;
    // Thresholds are zero-extended and compared live; nothing is latched here.
    assign almost_empty = (r_count <= {1'b0, almost_empty_threshold});
    assign almost_full  = (r_count >= {1'b0, almost_full_threshold});
    assign error        = r_error;

endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Synchronous single-clock FIFO with programmable almost-empty/almost-full thresholds; the per-channel storage element of the transaction layer. One instance exists per channel, and its `empty` output drives one bit of the layer FSM's `FIFOs_empty` bus. The thresholds it compares against are the `almost_empty_threshold` / `almost_full_threshold` values latched by that FSM during INIT. It also reports overflow and underflow errors.

## Interface
- FIFO_DEPTH, 8, number of words; must be a power of 2
- FIFO_WORD_SIZE, 10, data width in bits
- FIFO_PTR_SIZE, $clog2(FIFO_DEPTH), pointer width
- clk  in  1  single clock; all state changes on its rising edge
- reset_L  in  1  asynchronous, active-low reset
- push  in  1  write request, sampled on the rising edge
- pop  in  1  read request, sampled on the rising edge
- data_in  in  FIFO_WORD_SIZE  write data, captured on an accepted push
- almost_empty_threshold  in  FIFO_PTR_SIZE  almost-empty level, from the layer FSM
- almost_full_threshold  in  FIFO_PTR_SIZE  almost-full level, from the layer FSM
- data_out  out  FIFO_WORD_SIZE  registered read data
- valid_out  out  1  data_out holds a newly popped word this cycle
- count  out  FIFO_PTR_SIZE+1  current occupancy, 0..FIFO_DEPTH
- empty  out  1  count == 0
- full  out  1  count == FIFO_DEPTH
- almost_empty  out  1  count <= almost_empty_threshold
- almost_full  out  1  count >= almost_full_threshold
- error  out  1  sticky overflow/underflow indicator

## Operation
- Storage is an array of FIFO_DEPTH words with write pointer wr_ptr and read pointer rd_ptr, each FIFO_PTR_SIZE bits.
- Pointers wrap naturally modulo FIFO_DEPTH; there is no explicit compare-and-clear.
- count is a separate FIFO_PTR_SIZE+1-bit register; pointers are never used to derive full/empty.
- **Push accepted** when push=1 and (full=0, or pop is also accepted in the same cycle).
  - Accepted push: mem[wr_ptr] <= data_in, wr_ptr increments.
- **Pop accepted** when pop=1 and empty=0.
  - Accepted pop: data_out <= mem[rd_ptr], rd_ptr increments, valid_out <= 1.
- Otherwise valid_out <= 0 and data_out holds its last value.
- count update per edge:
  - push only: count+1
  - pop only: count−1
  - both accepted, or neither: unchanged
- **Full + push + pop:** both accepted; count stays FIFO_DEPTH; the oldest word goes out and the new word is written into the freed slot.
- **Empty + push + pop:** push accepted, pop rejected (no read-through); count becomes 1, valid_out=0, error sets.
- **Overflow:** push while full without pop. Data is dropped, wr_ptr and count are unchanged, error sets.
- **Underflow:** pop while empty. Pointers are unchanged, valid_out=0, error sets.
- error stays set until reset_L is asserted.
- Flag generation:
  - empty, full, almost_empty and almost_full are combinational from count and the threshold inputs.
  - Thresholds are zero-extended to FIFO_PTR_SIZE+1 before comparison.
  - A threshold change takes effect in the same cycle; nothing is latched inside this block.
- Memory contents are not reset.

## Timing
- Reset (asynchronous assert, released synchronously by clk) sets: wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0.
- Resulting output values after reset:
  - empty=1, full=0, almost_empty=1
  - almost_full=1 only when almost_full_threshold==0
- Reset asserted mid-operation immediately discards all contents; the flags take their reset values without waiting for a clock.
- Read latency is 1 cycle: a pop sampled at edge k puts the word on data_out with valid_out=1 after edge k, for exactly one cycle unless pop is accepted again at edge k+1.
- Back-to-back pops stream one word per cycle.
- Write-to-read latency is 1 cycle: a word pushed at edge k is poppable at edge k+1 at the earliest.
- Flags and count reflect the update at edge k from edge k onward. empty deasserts after the first accepted push edge.

## Test plan
- **Reset/defaults:** reset_L=0 with thresholds 2/6 -> count=0, empty=1, almost_empty=1, full=0, almost_full=0, error=0, valid_out=0, data_out=0.
- **Fill and overflow:** 8 pushes of 0x001..0x008, then a 9th push of 0x3FF with thresholds 2/6.
  - almost_empty drops when count reaches 3; almost_full rises when count reaches 6; full=1 after the 8th push.
  - The 9th push is dropped, count stays 8, error=1.
- **Drain order:** 8 consecutive pops from a full FIFO.
  - data_out reads 0x001..0x008 on successive cycles with valid_out=1.
  - empty=1 after the last pop; a 9th pop gives valid_out=0.
- **Simultaneous push/pop:**
  - At full: push 0x155 with pop -> count stays 8, oldest word out, 0x155 read last.
  - At empty: push with pop -> count=1, valid_out=0, error=1.
- **Threshold change live:** count=4, change almost_full_threshold 6->4 -> almost_full=1 in the same cycle, with no clock edge needed.
- **Mid-operation reset:** with count=5, assert reset_L=0 between edges -> count=0, empty=1, error=0 before the next edge; after release, a push/pop of 0x2AA returns 0x2AA.
